// File: rtl/mem_pkg.sv
// Shared encodings for the load/store front end: access sizes, fault codes,
// FSM state type and the request fault classifier.
package mem_pkg;

  typedef logic [1:0] size_t;
  typedef logic [1:0] fault_t;
  typedef logic       state_t;

  localparam size_t SZ_BYTE = 2'b00;
  localparam size_t SZ_HALF = 2'b01;
  localparam size_t SZ_WORD = 2'b10;
  localparam size_t SZ_ILL  = 2'b11;

  localparam fault_t FLT_OK       = 2'b00;
  localparam fault_t FLT_MISALIGN = 2'b01;
  localparam fault_t FLT_RANGE    = 2'b10;
  localparam fault_t FLT_SIZE     = 2'b11;

  localparam state_t ST_IDLE   = 1'b0;
  localparam state_t ST_RMW_WR = 1'b1;

  // Priority: illegal size, then misalignment, then word index out of range.
  function automatic fault_t classify(input size_t size, input logic [31:0] addr,
                                      input logic [31:0] mem_words);
    fault_t f;
    if (size == SZ_ILL)
      f = FLT_SIZE;
    else if ((size == SZ_HALF && addr[0]) || (size == SZ_WORD && addr[1:0] != 2'b00))
      f = FLT_MISALIGN;
    else if ({2'b00, addr[31:2]} >= mem_words)
      f = FLT_RANGE;
    else
      f = FLT_OK;
    return f;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: extracts and extends load data from a
// memory word, and merges sub-word store data into an existing word.
module mem_lane_align
  import mem_pkg::*;
(
  input  logic [1:0]  lane,
  input  size_t       size,
  input  logic        is_unsigned,
  input  logic [31:0] old_word,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merged_word
);

  logic [4:0]  shamt;
  logic [31:0] shifted;
  logic [31:0] lane_mask;

  // Lane select, load extension and store merge, all keyed by the low address bits.
  always_comb begin
    // NOTE: every output gets a value before any branch, so no latch can be inferred.
    shamt       = 5'd0;
    load_data   = old_word;
    lane_mask   = 32'hFFFF_FFFF;
    case (size)
      SZ_BYTE: begin
        shamt     = {lane, 3'b000};
        lane_mask = 32'h0000_00FF << shamt;
      end
      SZ_HALF: begin
        shamt     = {lane[1], 4'b0000};
        lane_mask = 32'h0000_FFFF << shamt;
      end
      default: ;
    endcase
    shifted = old_word >> shamt;
    case (size)
      SZ_BYTE: load_data = is_unsigned ? {24'h0, shifted[7:0]}
                                       : {{24{shifted[7]}}, shifted[7:0]};
      SZ_HALF: load_data = is_unsigned ? {16'h0, shifted[15:0]}
                                       : {{16{shifted[15]}}, shifted[15:0]};
      default: ;
    endcase
    merged_word = (old_word & ~lane_mask) | ((wdata << shamt) & lane_mask);
  end

endmodule

// File: rtl/mem_access_unit.sv
// Load/store front end for the word-addressed data_mem. Word stores write
// directly in the accept cycle; byte/half stores read the old word, merge,
// and write it back one cycle later from the RMW_WR state.
module mem_access_unit
  import mem_pkg::*;
#(
  parameter int MEM_WORDS = 1024,
  parameter int TAG_W     = 5
) (
  input  logic             clk,
  input  logic             reset_b,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_is_store,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [31:0]      req_addr,
  input  logic [31:0]      req_wdata,
  input  logic [TAG_W-1:0] req_tag,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_rdata,
  output logic [TAG_W-1:0] rsp_tag,
  output logic             rsp_is_store,
  output logic [1:0]       rsp_fault,
  output logic [31:0]      mem_read_addr,
  output logic [31:0]      mem_write_addr,
  output logic             mem_write_en,
  output logic [31:0]      mem_write_data,
  input  logic [31:0]      mem_read_data
);

  state_t           state;
  logic [31:0]      merge_buf;
  logic [31:0]      rmw_idx;
  logic [TAG_W-1:0] rmw_tag;

  logic [31:0] req_idx;
  fault_t      req_fault;
  logic        accept;
  logic        word_store;
  logic        sub_store;
  logic [31:0] load_data;
  logic [31:0] merged_word;

  assign req_idx       = {2'b00, req_addr[31:2]};
  assign req_fault     = classify(req_size, req_addr, 32'(MEM_WORDS));
  assign req_ready     = (state == ST_IDLE) && (!rsp_valid || rsp_ready);
  assign accept        = req_valid && req_ready;
  assign word_store    = req_is_store && (req_fault == FLT_OK) && (req_size == SZ_WORD);
  assign sub_store     = req_is_store && (req_fault == FLT_OK) && (req_size != SZ_WORD);
  assign mem_read_addr = req_idx;

  mem_lane_align u_lane_align (
    .lane        (req_addr[1:0]),
    .size        (req_size),
    .is_unsigned (req_unsigned),
    .old_word    (mem_read_data),
    .wdata       (req_wdata),
    .load_data   (load_data),
    .merged_word (merged_word)
  );

  // Memory write port: direct word stores when idle, merged word in RMW_WR.
  always_comb begin
    mem_write_en   = 1'b0;
    mem_write_addr = req_idx;
    mem_write_data = req_wdata;
    if (state == ST_RMW_WR) begin
      mem_write_en   = 1'b1;
      mem_write_addr = rmw_idx;
      mem_write_data = merge_buf;
    end else if (accept && word_store) begin
      mem_write_en = 1'b1;
    end
    // Abandon any write while reset is held so memory is never touched mid-reset.
    if (reset_b)
      mem_write_en = 1'b0;
  end

  // FSM, merge buffer and response register.
  always_ff @(posedge clk or posedge reset_b) begin
    if (reset_b) begin
      state        <= ST_IDLE;
      // NOTE: the merge buffer is a plain register, so it is reset like any other state.
      merge_buf    <= 32'h0;
      rmw_idx      <= 32'h0;
      rmw_tag      <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= 32'h0;
      rsp_tag      <= '0;
      rsp_is_store <= 1'b0;
      rsp_fault    <= FLT_OK;
    end else begin
      // NOTE: non-blocking so the handshake clear below can be overridden by a completion.
      if (rsp_valid && rsp_ready)
        rsp_valid <= 1'b0;
      if (state == ST_RMW_WR) begin
        rsp_valid    <= 1'b1;
        rsp_rdata    <= 32'h0;
        rsp_tag      <= rmw_tag;
        rsp_is_store <= 1'b1;
        rsp_fault    <= FLT_OK;
        state        <= ST_IDLE;
      end else if (accept) begin
        if (sub_store) begin
          merge_buf <= merged_word;
          rmw_idx   <= req_idx;
          rmw_tag   <= req_tag;
          state     <= ST_RMW_WR;
        end else begin
          rsp_valid    <= 1'b1;
          rsp_rdata    <= (!req_is_store && req_fault == FLT_OK) ? load_data : 32'h0;
          rsp_tag      <= req_tag;
          rsp_is_store <= req_is_store;
          rsp_fault    <= req_fault;
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: a behavioural data_mem, a
// byte-level reference model feeding an expectation queue, and a monitor
// that compares every accepted response against it.
module tb_mem_access_unit;

  localparam int MEM_WORDS = 1024;

  typedef struct {
    logic [31:0] rdata;
    logic [4:0]  tag;
    logic        is_store;
    logic [1:0]  fault;
    int          exp_cyc;
    bit          strict;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_b;
  logic        req_valid, req_ready, req_is_store, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_tag;
  logic        rsp_valid, rsp_ready, rsp_is_store;
  logic [31:0] rsp_rdata;
  logic [4:0]  rsp_tag;
  logic [1:0]  rsp_fault;
  logic [31:0] mem_read_addr, mem_write_addr, mem_write_data, mem_read_data;
  logic        mem_write_en;

  logic [31:0] env_mem [MEM_WORDS];
  logic [31:0] ref_mem [MEM_WORDS];
  bit          init_done = 1'b0;
  int          wr_count = 0;
  logic [31:0] last_wr_addr, last_wr_data;

  exp_t exp_q[$];
  exp_t mon_e;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   exp_wr = 0;
  bit   strict_mode = 1'b1;
  bit   rand_bp = 1'b0;

  always #5 clk = ~clk;

  mem_access_unit #(.MEM_WORDS(MEM_WORDS), .TAG_W(5)) dut (
    .clk(clk), .reset_b(reset_b),
    .req_valid(req_valid), .req_ready(req_ready), .req_is_store(req_is_store),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_tag(req_tag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_tag(rsp_tag), .rsp_is_store(rsp_is_store), .rsp_fault(rsp_fault),
    .mem_read_addr(mem_read_addr), .mem_write_addr(mem_write_addr),
    .mem_write_en(mem_write_en), .mem_write_data(mem_write_data),
    .mem_read_data(mem_read_data)
  );

  function automatic logic [31:0] seed_word(input int i);
    return (32'(i) * 32'h9E37_79B9) ^ 32'h5A5A_0F0F;
  endfunction

  // Behavioural data_mem: asynchronous read, write on the rising edge.
  assign mem_read_data = (mem_read_addr < MEM_WORDS) ? env_mem[mem_read_addr[9:0]] : 32'h0;

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!init_done) begin
      for (int i = 0; i < MEM_WORDS; i++) env_mem[i] <= seed_word(i);
      init_done <= 1'b1;
    end else if (mem_write_en) begin
      wr_count     <= wr_count + 1;
      last_wr_addr <= mem_write_addr;
      last_wr_data <= mem_write_data;
      if (mem_write_addr < MEM_WORDS) env_mem[mem_write_addr[9:0]] <= mem_write_data;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference model: applies the request to ref_mem byte by byte and
  // returns the response writeback should see.
  task automatic model(input logic st, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd,
                       input logic [4:0] tag, output exp_t e);
    longint unsigned a = addr;
    int nb, off, idx, lat;
    logic [31:0] w, v;
    e.tag = tag; e.is_store = st; e.rdata = 32'h0; e.strict = strict_mode;
    lat = 1;
    if (sz == 2'd3) e.fault = 2'd3;
    else begin
      nb = 1 << sz;
      if (a % nb != 0) e.fault = 2'd1;
      else if (a / 4 >= MEM_WORDS) e.fault = 2'd2;
      else e.fault = 2'd0;
    end
    if (e.fault == 2'd0) begin
      idx = int'(a / 4); off = int'(a % 4); w = ref_mem[idx];
      if (st) begin
        for (int i = 0; i < nb; i++) w[8*(off+i) +: 8] = wd[8*i +: 8];
        ref_mem[idx] = w;
        exp_wr++;
        if (nb < 4) lat = 2;
      end else begin
        v = 32'h0;
        for (int i = 0; i < nb; i++) v[8*i +: 8] = w[8*(off+i) +: 8];
        if (!uns && nb < 4 && v[8*nb-1])
          for (int i = nb; i < 4; i++) v[8*i +: 8] = 8'hFF;
        e.rdata = v;
      end
    end
    e.exp_cyc = cyc + lat;
  endtask

  // Drive one request from just after a rising edge; returns just after the accept edge.
  task automatic send(input logic st, input logic [1:0] sz, input logic uns,
                      input logic [31:0] addr, input logic [31:0] wd,
                      input logic [4:0] tag, output exp_t e, output int waits);
    req_valid = 1'b1; req_is_store = st; req_size = sz; req_unsigned = uns;
    req_addr = addr; req_wdata = wd; req_tag = tag;
    waits = 0;
    @(negedge clk);
    while (!req_ready && waits < 200) begin
      waits++;
      @(negedge clk);
    end
    if (!req_ready) begin
      check("req_accept_timeout", 32'h0, 32'h1);
      e.rdata = 32'h0; e.tag = tag; e.is_store = st; e.fault = 2'd0;
      e.exp_cyc = 0; e.strict = 1'b0;
    end else begin
      model(st, sz, uns, addr, wd, tag, e);
      exp_q.push_back(e);
    end
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  // Checks the response presented in the cycle after a 1-cycle operation.
  task automatic expect_rsp(input string name, input logic [31:0] rdata, input logic [1:0] fault);
    @(negedge clk);
    check({name, "_valid"}, 32'(rsp_valid), 32'h1);
    check({name, "_rdata"}, rsp_rdata, rdata);
    check({name, "_fault"}, 32'(rsp_fault), 32'(fault));
    @(posedge clk); #1;
  endtask

  // Monitor: pops and compares whenever a response is handed to writeback.
  always @(negedge clk) begin
    if (!reset_b && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0)
        check("rsp_unexpected", 32'h1, 32'h0);
      else begin
        mon_e = exp_q.pop_front();
        check("rsp_rdata", rsp_rdata, mon_e.rdata);
        check("rsp_tag", 32'(rsp_tag), 32'(mon_e.tag));
        check("rsp_is_store", 32'(rsp_is_store), 32'(mon_e.is_store));
        check("rsp_fault", 32'(rsp_fault), 32'(mon_e.fault));
        if (mon_e.strict) check("rsp_latency", 32'(cyc), 32'(mon_e.exp_cyc));
      end
    end
  end

  // Random backpressure on the response side.
  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_bp) rsp_ready = ($urandom % 4) != 0;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int   w, wr0, k, bad;
    logic [1:0]  sz;
    logic [31:0] addr;
    for (int i = 0; i < MEM_WORDS; i++) ref_mem[i] = seed_word(i);
    reset_b = 1'b1; req_valid = 1'b0; req_is_store = 1'b0; req_size = 2'b00;
    req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0; req_tag = 5'h0;
    rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rst_rsp_rdata", rsp_rdata, 32'h0);
    check("rst_rsp_tag", 32'(rsp_tag), 32'h0);
    check("rst_rsp_is_store", 32'(rsp_is_store), 32'h0);
    check("rst_rsp_fault", 32'(rsp_fault), 32'h0);
    check("rst_mem_write_en", 32'(mem_write_en), 32'h0);
    @(posedge clk); #1;
    reset_b = 1'b0;

    // Word store then load to the same word.
    wr0 = wr_count;
    send(1'b1, 2'b10, 1'b0, 32'h4, 32'hDEAD_BEEF, 5'd1, e, w);
    check("st_word_writes", 32'(wr_count - wr0), 32'h1);
    check("st_word_addr", last_wr_addr, 32'h1);
    check("st_word_data", last_wr_data, 32'hDEAD_BEEF);
    send(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd2, e, w);
    expect_rsp("ld_word", 32'hDEAD_BEEF, 2'b00);

    // Signed and unsigned sub-word loads.
    send(1'b1, 2'b10, 1'b0, 32'h4, 32'h80FF_7F01, 5'd3, e, w);
    send(1'b0, 2'b00, 1'b0, 32'h7, 32'h0, 5'd4, e, w);
    expect_rsp("ld_byte_s", 32'hFFFF_FF80, 2'b00);
    send(1'b0, 2'b00, 1'b1, 32'h6, 32'h0, 5'd5, e, w);
    expect_rsp("ld_byte_u", 32'h0000_00FF, 2'b00);
    send(1'b0, 2'b01, 1'b0, 32'h4, 32'h0, 5'd6, e, w);
    expect_rsp("ld_half_s", 32'h0000_7F01, 2'b00);

    // Sub-word read-modify-write.
    send(1'b1, 2'b10, 1'b0, 32'h8, 32'h1122_3344, 5'd7, e, w);
    wr0 = wr_count;
    send(1'b1, 2'b01, 1'b0, 32'hA, 32'h0000_AABB, 5'd8, e, w);
    @(negedge clk);
    check("rmw_req_ready_low", 32'(req_ready), 32'h0);
    check("rmw_write_en", 32'(mem_write_en), 32'h1);
    check("rmw_write_addr", mem_write_addr, 32'h2);
    check("rmw_write_data", mem_write_data, 32'hAABB_3344);
    @(posedge clk); #1;
    check("rmw_single_write", 32'(wr_count - wr0), 32'h1);
    check("rmw_mem_word", env_mem[2], 32'hAABB_3344);
    @(negedge clk);
    check("rmw_rsp_valid", 32'(rsp_valid), 32'h1);
    check("rmw_req_ready_back", 32'(req_ready), 32'h1);
    @(posedge clk); #1;

    // Faults.
    send(1'b0, 2'b01, 1'b0, 32'h5, 32'h0, 5'd9, e, w);
    expect_rsp("flt_misalign", 32'h0, 2'b01);
    wr0 = wr_count;
    send(1'b1, 2'b10, 1'b0, 32'h1000, 32'h1234_5678, 5'd10, e, w);
    expect_rsp("flt_range", 32'h0, 2'b10);
    check("flt_range_no_write", 32'(wr_count - wr0), 32'h0);
    send(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 5'd11, e, w);
    expect_rsp("flt_size", 32'h0, 2'b11);

    // Backpressure: response held, requests stalled, accept when ready rises.
    strict_mode = 1'b0;
    rsp_ready = 1'b0;
    send(1'b0, 2'b10, 1'b0, 32'h4, 32'h0, 5'd12, e, w);
    req_valid = 1'b1; req_is_store = 1'b0; req_size = 2'b10; req_addr = 32'h8; req_tag = 5'd13;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_rsp_valid", 32'(rsp_valid), 32'h1);
      check("bp_rsp_rdata", rsp_rdata, 32'h80FF_7F01);
      check("bp_req_ready", 32'(req_ready), 32'h0);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    send(1'b0, 2'b10, 1'b0, 32'h8, 32'h0, 5'd13, e, w);
    check("bp_accept_waits", 32'(w), 32'h0);
    expect_rsp("bp_second_load", 32'hAABB_3344, 2'b00);

    // Reset during RMW_WR: write abandoned, no response.
    req_valid = 1'b1; req_is_store = 1'b1; req_size = 2'b00; req_addr = 32'h9;
    req_wdata = 32'h55; req_tag = 5'd14;
    @(negedge clk);
    check("rstrmw_accept", 32'(req_ready), 32'h1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(negedge clk);
    reset_b = 1'b1;
    @(posedge clk); #1;
    reset_b = 1'b0;
    @(negedge clk);
    check("rstrmw_mem_kept", env_mem[2], 32'hAABB_3344);
    check("rstrmw_rsp_valid", 32'(rsp_valid), 32'h0);
    check("rstrmw_req_ready", 32'(req_ready), 32'h1);
    @(posedge clk); #1;

    // Randomized traffic with random response backpressure.
    rand_bp = 1'b1;
    for (int n = 0; n < 400; n++) begin
      if ($urandom % 4 == 0) begin
        @(posedge clk); #1;
      end
      sz = ($urandom % 16 == 0) ? 2'b11 : 2'($urandom % 3);
      if ($urandom % 10 == 0)
        addr = 32'($urandom_range(MEM_WORDS - 2, MEM_WORDS + 2)) * 4 + 32'($urandom % 4);
      else if ($urandom % 50 == 0)
        addr = $urandom;
      else
        addr = 32'($urandom_range(0, 31)) * 4 + 32'($urandom % 4);
      send(1'($urandom % 2), sz, 1'($urandom % 2), addr, $urandom, 5'($urandom), e, w);
    end
    rand_bp = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(posedge clk);
      k++;
    end
    #1;
    check("drain_queue_empty", 32'(exp_q.size()), 32'h0);
    bad = 0;
    for (int i = 0; i < MEM_WORDS; i++) if (env_mem[i] !== ref_mem[i]) bad++;
    check("mem_image_mismatches", 32'(bad), 32'h0);
    check("write_count", 32'(wr_count), 32'(exp_wr));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Load/store front end for the word-addressed `data_mem`. Sits directly upstream of `data_mem`, between the execute stage and writeback. Accepts byte-addressed load/store requests over a valid/ready handshake and drives the memory's read/write ports. Performs sub-word stores as read-modify-write and returns sign- or zero-extended load data with a fault code.

## Interface
Parameters:
- `MEM_WORDS`, 1024: depth of `data_mem` in 32-bit words; word indices at or above this fault.
- `TAG_W`, 5: width of the destination-register tag carried with each request.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset_b` in 1: asynchronous, active-high reset.
- `req_valid` in 1: request present.
- `req_ready` out 1: request accepted when both valid and ready are high at a rising edge.
- `req_is_store` in 1: 1 = store, 0 = load.
- `req_size` in 2: 00 = byte, 01 = half, 10 = word; 11 is illegal.
- `req_unsigned` in 1: loads only; 1 = zero-extend, 0 = sign-extend.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data, right-aligned; only the low `size` bytes are used.
- `req_tag` in TAG_W: passed through to the response unchanged.
- `rsp_valid` out 1: response held until `rsp_ready` is high.
- `rsp_ready` in 1: writeback accepts the response.
- `rsp_rdata` out 32: extended load data; 0 for stores and faults.
- `rsp_tag` out TAG_W: tag of the request.
- `rsp_is_store` out 1: echoes the request kind.
- `rsp_fault` out 2: 00 = ok, 01 = misaligned, 10 = out of range, 11 = illegal size.
- `mem_read_addr` out 32: word index `{2'b0, addr[31:2]}`.
- `mem_write_addr` out 32: word index.
- `mem_write_en` out 1: `data_mem` writes on the rising edge while this is high.
- `mem_write_data` out 32: full word to write.
- `mem_read_data` in 32: asynchronous read data from `data_mem`.

## Operation
- FSM states:
  - `IDLE`: `req_ready = !rsp_valid || rsp_ready`.
  - `RMW_WR`: `req_ready = 0`.
- Fault check on accept, priority illegal size > misaligned > out of range:
  - Misaligned: half with `addr[0] != 0`, or word with `addr[1:0] != 0`.
  - Out of range: `addr[31:2] >= MEM_WORDS`.
  - A faulting request never asserts `mem_write_en`. Its response carries the fault with `rdata = 0`.
- Load (IDLE, accepted):
  - `mem_read_addr` is driven from `req_addr`.
  - The selected byte/half lane (`addr[1:0]` picks the lane, little-endian) is extended and registered into `rsp_rdata`.
- Word store (IDLE, accepted): `mem_write_en = 1`, `mem_write_data = req_wdata`, both combinational in the accept cycle.
- Sub-word store (IDLE, accepted):
  - Read the old word.
  - Register the merged word (new byte/half replaces its lane, other lanes kept) plus the word index.
  - Go to `RMW_WR`.
- `RMW_WR`: `mem_write_en = 1` with the registered word and index. Load the response register, return to `IDLE`.
- `mem_write_en = 0` in every other cycle. When idle, `mem_read_addr` and `mem_write_addr` follow the `req_addr` word index.
- Response register:
  - Set when an operation completes.
  - Cleared by `rsp_valid && rsp_ready` unless a new completion loads it in the same cycle; completion wins.

## Timing
- Reset values:
  - State `IDLE`.
  - `rsp_valid = 0`, `rsp_rdata = 0`, `rsp_tag = 0`, `rsp_is_store = 0`, `rsp_fault = 00`.
  - Merge buffer 0.
  - `mem_write_en = 0`, and it is forced low while `reset_b` is high.
- Latency, from accept edge to `rsp_valid` high:
  - 1 cycle for loads, word stores and faults.
  - 2 cycles for sub-word stores.
- Throughput:
  - One request per cycle for 1-cycle operations while `rsp_ready` stays high.
  - A sub-word store blocks the next accept for one cycle.
- Back-to-back store then load to the same word: the write commits on the accept edge of the store (or the `RMW_WR` edge), so the following load reads the new value.
- Backpressure: with `rsp_valid = 1` and `rsp_ready = 0`, `req_ready = 0`; response outputs hold stable.
- Reset asserted in `RMW_WR`: the write is abandoned, memory is unchanged, and the block returns to `IDLE` with no response.

## Structure
- Shared package (`mem_pkg`):
  - Size encodings `SZ_BYTE`, `SZ_HALF`, `SZ_WORD`.
  - Fault codes `FLT_OK`, `FLT_MISALIGN`, `FLT_RANGE`, `FLT_SIZE`.
  - FSM state type.
- One natural sub-module, `mem_lane_align`, is purely combinational:
  - Load path: lane extract plus sign/zero extension.
  - Store path: lane merge.
  - Both driven by `addr[1:0]`, size and unsigned.

## Test plan
- Word store then load: store `0xDEADBEEF` at addr 0x4, then load word at 0x4 → one write to index 1; `rsp_rdata = 0xDEADBEEF`, fault 00, each response one cycle after accept.
- Signed/unsigned byte load: word 1 = `0x80FF7F01`.
  - Load byte signed at 0x7 → `0xFFFFFF80`.
  - Load byte unsigned at 0x6 → `0x000000FF`.
  - Load half signed at 0x4 → `0x00007F01`.
- Sub-word RMW: word 2 = `0x11223344`, store half `0xAABB` at 0xA → `req_ready` low for one cycle, then a single write of `0xAABB3344` to index 2; response 2 cycles after accept.
- Faults:
  - Half load at 0x5 → fault 01.
  - Word store at 0x1000 (index 1024) → fault 10, `mem_write_en` never high.
  - Size 11 → fault 11.
- Backpressure: `rsp_ready = 0` for 3 cycles after a load → `rsp_valid` and `rsp_rdata` held, `req_ready = 0`; the next request is accepted in the cycle `rsp_ready` rises.
- Reset in `RMW_WR`: pulse `reset_b` high during the write cycle → memory word unchanged, `rsp_valid = 0`, `req_ready = 1` after release.
